// File: rtl/chk_pkg.sv
// Shared definitions for the response checker: FSM state encoding and parameter limits.
package chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    localparam int LATENCY_MAX = 15;
    localparam int DRAIN_CNT_W = $clog2(LATENCY_MAX + 1);
    localparam int ERR_W_MIN   = 1;
    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 256;

endpackage

// File: rtl/chk_delay_line.sv
// Fixed-depth shift register that realigns driven stimulus with the DUT response.
module chk_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign q_o = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe_q [DEPTH];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign q_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/response_checker.sv
// Drives a fixed serial pattern into a DUT and counts mismatches in its delayed response.
module response_checker
    import chk_pkg::*;
#(
    parameter int                 PAT_LEN = 16,
    parameter logic [PAT_LEN-1:0] PATTERN = 16'hA5C3,
    parameter int                 LATENCY = 1,
    parameter int                 ERR_W   = 8
) (
    input  logic                       newCLK,
    input  logic                       global_reset,
    input  logic                       start,
    input  logic                       dut_out,
    output logic                       stim_out,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_count,
    output logic [$clog2(PAT_LEN)-1:0] first_err_idx
);

    localparam int IDX_W = $clog2(PAT_LEN);
    localparam int DL_W  = IDX_W + 2;

    chk_state_e             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DRAIN_CNT_W-1:0] drain_q;
    logic                   stim_q, busy_q, done_q, pass_q;
    logic [ERR_W-1:0]       err_q, err_d;
    logic [IDX_W-1:0]       first_q, first_d;

    logic [DL_W-1:0]        dl_in, dl_out;
    logic                   exp_vld, exp_bit, mismatch;
    logic [IDX_W-1:0]       exp_idx;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Each driven bit travels with its index and a valid flag so compare never re-reads PATTERN.
    assign dl_in = {(state_q == DRIVE), idx_q, stim_q};

    chk_delay_line #(
        .DEPTH (LATENCY),
        .WIDTH (DL_W)
    ) u_dly (
        .clk_i (newCLK),
        .rst_i (global_reset),
        .d_i   (dl_in),
        .q_o   (dl_out)
    );

    assign exp_vld  = dl_out[DL_W-1];
    assign exp_idx  = dl_out[1 +: IDX_W];
    assign exp_bit  = dl_out[0];
    assign mismatch = exp_vld && (dut_out != exp_bit);

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (mismatch) begin
            err_d = sat_inc(err_q);
            if (err_q == '0) first_d = exp_idx;
        end
    end

    always_ff @(posedge newCLK or posedge global_reset) begin
        if (global_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            stim_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            err_q   <= err_d;
            first_q <= first_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        stim_q  <= PATTERN[0];
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        first_q <= '0;
                    end
                end
                DRIVE: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(PAT_LEN - 1)) begin
                        stim_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end
                    end else begin
                        stim_q <= PATTERN[idx_q + IDX_W'(1)];
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + DRAIN_CNT_W'(1);
                    // The last in-flight bit is compared on this same edge, so pass uses err_d.
                    if (drain_q == DRAIN_CNT_W'(LATENCY - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim_out      = stim_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_response_checker.sv
// Bench for response_checker: loopback, stuck, bit-flip, inverting, reset-abort, ignored-start and random responses.
module tb_response_checker;

    localparam logic [15:0] PAT = 16'hA5C3;
    localparam int          LAT = 1;

    logic       newCLK = 1'b0;
    logic       rst, start;
    logic       dut_in, stim_out, busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] first_err_idx;

    logic       dut3_in, stim3, busy3, done3, pass3;
    logic [2:0] err3;
    logic [3:0] first3;

    int   mode;
    int   run_cyc;
    bit   resp [32];
    logic lb_q  = 1'b0;
    logic lb3_q = 1'b0;

    int   n_vec = 0;
    int   n_bad = 0;
    int   busy_n, done_n;
    bit   stim_cap [16];

    always #5 newCLK = ~newCLK;

    response_checker u_dut (
        .newCLK        (newCLK),
        .global_reset  (rst),
        .start         (start),
        .dut_out       (dut_in),
        .stim_out      (stim_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    response_checker #(.ERR_W(3)) u_dut3 (
        .newCLK        (newCLK),
        .global_reset  (rst),
        .start         (start),
        .dut_out       (dut3_in),
        .stim_out      (stim3),
        .busy          (busy3),
        .done          (done3),
        .pass          (pass3),
        .err_count     (err3),
        .first_err_idx (first3)
    );

    // External "DUTs": single-flop loopback (optionally corrupting bit 5), inverting loopback, table replay.
    always @(posedge newCLK) begin
        lb_q  <= stim_out ^ (mode == 2 && run_cyc == 5);
        lb3_q <= stim3;
    end
    assign dut3_in = ~lb3_q;

    always_comb begin
        dut_in = lb_q;
        if (mode == 1) dut_in = 1'b0;
        else if (mode == 3) dut_in = (run_cyc >= 0 && run_cyc < 32) ? resp[run_cyc] : 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One accepted start, then a fixed 40-cycle observation window; optional stray starts and reset.
    task automatic run_once(input int inj_cyc, input bit start_in_done, input int rst_cyc);
        busy_n = 0;
        done_n = 0;
        @(negedge newCLK);
        start = 1'b1;
        @(negedge newCLK);
        start   = 1'b0;
        run_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_n++;
            if (done) done_n++;
            if (run_cyc < 16) stim_cap[run_cyc] = stim_out;
            start = (run_cyc == inj_cyc) || (start_in_done && done);
            if (run_cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_stim",  stim_out, 0);
                chk("rst_mid_busy",  busy, 0);
                chk("rst_mid_done",  done, 0);
                chk("rst_mid_pass",  pass, 0);
                chk("rst_mid_err",   err_count, 0);
                chk("rst_mid_first", first_err_idx, 0);
                @(negedge newCLK);
                rst = 1'b0;
            end
            @(negedge newCLK);
            run_cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int mode;
        int exp_err;
        int exp_first;
        int exp_pass;
        int exp_busy;
    } vec_t;

    initial begin
        vec_t tbl [3];
        bit   exp_stim [16];
        int   mm_q [$];
        int   exp_err;

        tbl[0] = '{0, 0, 0, 1, 17};
        tbl[1] = '{1, 8, 0, 0, 17};
        tbl[2] = '{2, 1, 5, 0, 17};
        exp_stim = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

        rst     = 1'b1;
        start   = 1'b0;
        mode    = 0;
        run_cyc = 100;
        #12;
        chk("reset_stim",  stim_out, 0);
        chk("reset_busy",  busy, 0);
        chk("reset_done",  done, 0);
        chk("reset_pass",  pass, 0);
        chk("reset_err",   err_count, 0);
        chk("reset_first", first_err_idx, 0);
        @(negedge newCLK);
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            mode = tbl[t].mode;
            run_once(-1, 1'b0, -1);
            chk($sformatf("t%0d_err", t),   err_count, tbl[t].exp_err);
            chk($sformatf("t%0d_first", t), first_err_idx, tbl[t].exp_first);
            chk($sformatf("t%0d_pass", t),  pass, tbl[t].exp_pass);
            chk($sformatf("t%0d_done", t),  done_n, 1);
            chk($sformatf("t%0d_busy", t),  busy_n, tbl[t].exp_busy);
            if (t == 0) begin
                for (int i = 0; i < 16; i++)
                    chk($sformatf("stim_bit%0d", i), stim_cap[i], exp_stim[i]);
                chk("inv_err_sat", err3, 7);
                chk("inv_pass",    pass3, 0);
                chk("inv_first",   first3, 0);
            end
        end

        // Abort during bit 8 of a failing run, then a clean run must pass.
        mode = 1;
        run_once(-1, 1'b0, 8);
        chk("abort_done_cnt", done_n, 0);
        chk("abort_busy_after", busy, 0);
        mode = 0;
        run_once(-1, 1'b0, -1);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_err",  err_count, 0);
        chk("post_rst_done", done_n, 1);

        // Starts during DRIVE and DONE are ignored.
        run_once(3, 1'b1, -1);
        chk("ign_start_done", done_n, 1);
        chk("ign_start_busy", busy_n, 17);
        chk("ign_start_pass", pass, 1);

        mode = 3;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                if ((r % 2 == 0) && c >= LAT && c < 16 + LAT)
                    resp[c] = PAT[c-LAT] ^ ($urandom_range(0, 5) == 0);
                else
                    resp[c] = 1'($urandom_range(0, 1));
            end
            mm_q.delete();
            for (int i = 0; i < 16; i++)
                if (resp[i+LAT] != PAT[i]) mm_q.push_back(i);
            exp_err = (mm_q.size() > 255) ? 255 : mm_q.size();
            run_once(-1, 1'b0, -1);
            chk($sformatf("rnd%0d_err", r),   err_count, exp_err);
            chk($sformatf("rnd%0d_first", r), first_err_idx, (mm_q.size() > 0) ? mm_q[0] : 0);
            chk($sformatf("rnd%0d_pass", r),  pass, (mm_q.size() == 0) ? 1 : 0);
            chk($sformatf("rnd%0d_done", r),  done_n, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
